vend_sequencer: RTL and testbench
=================================

VEND_SEQUENCER -- requirements
Module: vend_sequencer

Interface
REQ-001 SHALL have clk, input, 1, single clock; all state updates on its rising edge.
REQ-002 SHALL have reset, input, 1, synchronous active-high reset.
REQ-003 SHALL have coin, input, 2, 00 none, 01 = 5, 10 = 10, 11 = invalid; one coin per cycle.
REQ-004 SHALL have sel, input, 4, product request buttons, lane i on bit i, level-sampled.
REQ-005 SHALL have lane_empty, input, 4, lane i out of stock when bit i = 1.
REQ-006 SHALL have refund, input, 1, request return of all credit.
REQ-007 SHALL have motor_ack, input, 1, shared dispense motor completion, one-cycle pulse.
REQ-008 SHALL have motor_req, output, 1, dispense request to the shared motor.
REQ-009 SHALL have motor_lane, output, 2, lane index, valid while motor_req = 1.
REQ-010 SHALL have change_pulse, output, 1, one pulse = one 5-unit coin returned.
REQ-011 SHALL have coin_reject, output, 1, one-cycle pulse when an inserted coin is not credited.
REQ-012 SHALL have credit, output, 6, current registered credit in units of 1.
REQ-013 SHALL have busy, output, 1, high in any state other than IDLE.
REQ-014 SHALL have timeout_err, output, 1, one-cycle pulse when the motor fails to acknowledge.

Function
REQ-015 SHALL implement states IDLE, VEND, CHANGE; all outputs registered.
REQ-016 SHALL use prices: lane0 15, lane1 20, lane2 25, lane3 10; CREDIT_MAX 35.
REQ-017 IDLE: a valid coin SHALL add 5 or 10 to credit at the sampling edge, visible on credit the next cycle.
REQ-018 A coin taking credit above CREDIT_MAX, coin = 11, or any coin in VEND or CHANGE SHALL be rejected: credit unchanged, coin_reject = 1 the next cycle.
REQ-019 Lane i SHALL be eligible when sel[i] = 1, lane_empty[i] = 0, and registered credit >= price(i).
REQ-020 Among eligible lanes the lowest index SHALL win (fixed priority); ineligible requests SHALL be ignored without side effects.
REQ-021 On a grant in IDLE, the next cycle SHALL show state VEND, motor_req = 1, motor_lane = winner.
REQ-022 A coin in the same cycle as a grant SHALL be rejected; eligibility SHALL use pre-coin credit.
REQ-023 refund with credit > 0 and no grant SHALL enter CHANGE; a grant SHALL take precedence over refund; refund with credit = 0 SHALL be ignored.
REQ-024 VEND: motor_req SHALL hold until the edge sampling motor_ack = 1, then deassert with credit reduced by price.
REQ-025 After acknowledge, the block SHALL enter CHANGE if remaining credit > 0, else IDLE.
REQ-026 VEND SHALL count cycles with motor_req high; at TIMEOUT = 16 without ack it SHALL drop motor_req, pulse timeout_err, keep credit unchanged and enter CHANGE.
REQ-027 CHANGE: change_pulse SHALL alternate 1,0,1,0 starting the first CHANGE cycle, credit -5 per pulse, IDLE the cycle after the last pulse.
REQ-028 All credit values SHALL be multiples of 5, so CHANGE SHALL empty credit to exactly 0.
REQ-029 motor_ack outside VEND SHALL be ignored.

Reset
REQ-030 reset SHALL force IDLE and credit 0, set all outputs to 0 and clear the timeout counter at the next edge, in any state.
REQ-031 Reset during VEND or CHANGE SHALL discard credit without issuing change; inputs sampled during reset SHALL be ignored.

Structure
REQ-032 A shared package vend_pkg SHALL hold the coin encoding, the state enum, the price table, CREDIT_MAX and TIMEOUT.
REQ-033 A single sub-module vend_prio_arb SHALL implement the lowest-index eligibility arbiter (4 in, one-hot/index out).

Verification
REQ-034 coin 01, then 10; sel=0001 -> credit 15, motor_req with lane 0; ack -> credit 0, IDLE, no change_pulse.
REQ-035 coins 10,10,10 (30), sel=0110 -> lane 1 wins; ack -> credit 10, two change_pulses on alternate cycles, then IDLE.
REQ-036 credit 30, coin 10 -> coin_reject pulse, credit stays 30; coin 11 at credit 0 -> coin_reject.
REQ-037 credit 25, sel=0100, no ack -> motor_req high 16 cycles, timeout_err pulse, 5 change_pulses, credit 0.
REQ-038 credit 20, sel=1000 with lane_empty=1000 and refund=1 -> no vend, 4 change_pulses; sel=0001 with refund -> grant wins.
REQ-039 credit 20 in VEND, reset pulse -> next cycle IDLE, credit 0, motor_req 0, no change_pulse.

Source files
------------

// File: rtl/vend_pkg.sv
// Shared definitions for the vending sequencer: coin encoding, FSM states,
// price table, credit ceiling and motor timeout.
package vend_pkg;

  localparam int CREDIT_W = 6;
  localparam int LANES    = 4;
  localparam int TIMEOUT  = 16;
  localparam int TMO_W    = $clog2(TIMEOUT);

  localparam logic [CREDIT_W-1:0] CREDIT_MAX = 6'd35;
  localparam logic [CREDIT_W-1:0] COIN_STEP  = 6'd5;

  typedef enum logic [1:0] {
    COIN_NONE = 2'b00,
    COIN_5    = 2'b01,
    COIN_10   = 2'b10,
    COIN_BAD  = 2'b11
  } coin_e;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_VEND   = 2'd1,
    ST_CHANGE = 2'd2
  } state_e;

  function automatic logic [CREDIT_W-1:0] lane_price(input logic [1:0] lane);
    case (lane)
      2'd0:    lane_price = 6'd15;
      2'd1:    lane_price = 6'd20;
      2'd2:    lane_price = 6'd25;
      default: lane_price = 6'd10;
    endcase
  endfunction

  function automatic logic [CREDIT_W-1:0] coin_value(input logic [1:0] c);
    case (c)
      COIN_5:  coin_value = 6'd5;
      COIN_10: coin_value = 6'd10;
      default: coin_value = 6'd0;
    endcase
  endfunction

endpackage

// File: rtl/vend_sequencer_if.sv
// Customer-side and motor-side signal bundle of the vending sequencer.
interface vend_sequencer_if;
  import vend_pkg::*;

  logic [1:0]          coin;
  logic [LANES-1:0]    sel;
  logic [LANES-1:0]    lane_empty;
  logic                refund;
  logic                motor_ack;
  logic                motor_req;
  logic [1:0]          motor_lane;
  logic                change_pulse;
  logic                coin_reject;
  logic [CREDIT_W-1:0] credit;
  logic                busy;
  logic                timeout_err;

  modport master (
    output coin, sel, lane_empty, refund, motor_ack,
    input  motor_req, motor_lane, change_pulse, coin_reject, credit, busy, timeout_err
  );

  modport slave (
    input  coin, sel, lane_empty, refund, motor_ack,
    output motor_req, motor_lane, change_pulse, coin_reject, credit, busy, timeout_err
  );

endinterface

// File: rtl/vend_prio_arb.sv
// Fixed-priority arbiter: the lowest-indexed asserted request wins.
module vend_prio_arb
  import vend_pkg::*;
(
  input  logic [LANES-1:0] req,
  output logic [1:0]       grant_idx,
  output logic             grant_vld
);

  // Scan from the top down so the lowest index is the last to overwrite.
  always_comb begin
    grant_idx = 2'd0;
    grant_vld = 1'b0;
    for (int i = LANES - 1; i >= 0; i--) begin
      if (req[i]) begin
        grant_idx = 2'(i);
        grant_vld = 1'b1;
      end
    end
  end

endmodule

// File: rtl/vend_sequencer.sv
// Vending sequencer: accepts coins, grants one lane to the shared motor,
// waits for the motor acknowledge (with timeout) and pays change in 5-unit pulses.
module vend_sequencer
  import vend_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  vend_sequencer_if.slave  bus
);

  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT - 1);

  state_e              state_q, state_d;
  logic [CREDIT_W-1:0] credit_q, credit_d;
  logic [TMO_W-1:0]    tmo_q, tmo_d;
  logic [1:0]          lane_q, lane_d;
  logic                mreq_q, mreq_d;
  logic                pulse_q, pulse_d;
  logic                rej_q, rej_d;
  logic                terr_q, terr_d;
  logic                busy_q, busy_d;

  logic [LANES-1:0]    elig;
  logic [1:0]          grant_idx;
  logic                grant_vld;
  logic [CREDIT_W:0]   coin_sum;
  logic                coin_any, coin_ok;
  logic [CREDIT_W-1:0] rem;

  // Eligibility always uses the registered (pre-coin) credit.
  always_comb begin
    for (int i = 0; i < LANES; i++)
      elig[i] = bus.sel[i] & ~bus.lane_empty[i] & (credit_q >= lane_price(2'(i)));
  end

  vend_prio_arb u_arb (
    .req       (elig),
    .grant_idx (grant_idx),
    .grant_vld (grant_vld)
  );

  assign coin_any = (bus.coin != COIN_NONE);
  assign coin_sum = {1'b0, credit_q} + {1'b0, coin_value(bus.coin)};
  assign coin_ok  = ((bus.coin == COIN_5) || (bus.coin == COIN_10)) &&
                    (coin_sum <= {1'b0, CREDIT_MAX});
  assign rem      = credit_q - lane_price(lane_q);

  always_ff @(posedge clk) begin
    if (reset) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (grant_vld)                           state_d = ST_VEND;
        else if (bus.refund && credit_q != '0)   state_d = ST_CHANGE;
      end
      ST_VEND: begin
        if (bus.motor_ack)                       state_d = (rem != '0) ? ST_CHANGE : ST_IDLE;
        else if (tmo_q == TMO_LAST)              state_d = ST_CHANGE;
      end
      ST_CHANGE: begin
        if (pulse_q && credit_q == COIN_STEP)    state_d = ST_IDLE;
      end
      default:                                   state_d = ST_IDLE;
    endcase
  end

  // Next values of every registered output; credit drops on the edge ending a pulse.
  always_comb begin
    credit_d = credit_q;
    tmo_d    = tmo_q;
    lane_d   = lane_q;
    mreq_d   = mreq_q;
    pulse_d  = 1'b0;
    rej_d    = 1'b0;
    terr_d   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (grant_vld) begin
          mreq_d = 1'b1;
          lane_d = grant_idx;
          tmo_d  = '0;
          rej_d  = coin_any;
        end else begin
          if (coin_ok) credit_d = coin_sum[CREDIT_W-1:0];
          else         rej_d    = coin_any;
          pulse_d = (state_d == ST_CHANGE);
        end
      end
      ST_VEND: begin
        rej_d = coin_any;
        if (bus.motor_ack) begin
          mreq_d   = 1'b0;
          credit_d = rem;
          pulse_d  = (rem != '0);
        end else if (tmo_q == TMO_LAST) begin
          mreq_d  = 1'b0;
          terr_d  = 1'b1;
          pulse_d = 1'b1;
        end else begin
          tmo_d = tmo_q + TMO_W'(1);
        end
      end
      ST_CHANGE: begin
        rej_d = coin_any;
        if (pulse_q) credit_d = credit_q - COIN_STEP;
        else         pulse_d  = 1'b1;
      end
      default: ;
    endcase
    busy_d = (state_d != ST_IDLE);
  end

  // Output register stage
  always_ff @(posedge clk) begin
    if (reset) begin
      credit_q <= '0;
      tmo_q    <= '0;
      lane_q   <= '0;
      mreq_q   <= 1'b0;
      pulse_q  <= 1'b0;
      rej_q    <= 1'b0;
      terr_q   <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      credit_q <= credit_d;
      tmo_q    <= tmo_d;
      lane_q   <= lane_d;
      mreq_q   <= mreq_d;
      pulse_q  <= pulse_d;
      rej_q    <= rej_d;
      terr_q   <= terr_d;
      busy_q   <= busy_d;
    end
  end

  assign bus.motor_req    = mreq_q;
  assign bus.motor_lane   = lane_q;
  assign bus.change_pulse = pulse_q;
  assign bus.coin_reject  = rej_q;
  assign bus.credit       = credit_q;
  assign bus.busy         = busy_q;
  assign bus.timeout_err  = terr_q;

endmodule

// File: tb/tb_vend_sequencer.sv
// Directed bench for vend_sequencer: coin handling, vend, change, timeout,
// refund priority and reset behaviour against hand-computed expectations.
module tb_vend_sequencer;

  logic clk = 1'b0;
  logic reset;
  int   checks = 0;
  int   failures = 0;

  vend_sequencer_if bus();

  vend_sequencer dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs;
    bus.coin = 2'b00; bus.sel = 4'b0000; bus.lane_empty = 4'b0000;
    bus.refund = 1'b0; bus.motor_ack = 1'b0;
  endtask

  task automatic do_reset;
    clear_inputs();
    reset = 1'b1;
    tick();
    reset = 1'b0;
  endtask

  task automatic insert_coin(input logic [1:0] c);
    bus.coin = c;
    tick();
    bus.coin = 2'b00;
  endtask

  task automatic test_reset;
    do_reset();
    checks++; if (bus.credit !== 6'd0) begin failures++; $display("FAIL reset_credit got=%0d exp=0", bus.credit); end
    checks++; if (bus.busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", bus.busy); end
    checks++; if ({bus.motor_req, bus.change_pulse, bus.coin_reject, bus.timeout_err} !== 4'b0000) begin
      failures++; $display("FAIL reset_outputs got=%b exp=0000", {bus.motor_req, bus.change_pulse, bus.coin_reject, bus.timeout_err}); end
  endtask

  task automatic test_basic_vend;
    do_reset();
    insert_coin(2'b01);
    checks++; if (bus.credit !== 6'd5) begin failures++; $display("FAIL basic_credit5 got=%0d exp=5", bus.credit); end
    insert_coin(2'b10);
    checks++; if (bus.credit !== 6'd15) begin failures++; $display("FAIL basic_credit15 got=%0d exp=15", bus.credit); end
    bus.sel = 4'b0001; tick(); bus.sel = 4'b0000;
    checks++; if ({bus.motor_req, bus.motor_lane, bus.busy} !== 4'b1001) begin
      failures++; $display("FAIL basic_grant got=%b exp=1001", {bus.motor_req, bus.motor_lane, bus.busy}); end
    tick(); tick();
    checks++; if (bus.motor_req !== 1'b1) begin failures++; $display("FAIL basic_req_hold got=%b exp=1", bus.motor_req); end
    bus.motor_ack = 1'b1; tick(); bus.motor_ack = 1'b0;
    checks++; if ({bus.motor_req, bus.busy, bus.change_pulse} !== 3'b000 || bus.credit !== 6'd0) begin
      failures++; $display("FAIL basic_ack got req/busy/pulse=%b credit=%0d exp=000 credit=0", {bus.motor_req, bus.busy, bus.change_pulse}, bus.credit); end
    tick();
    checks++; if (bus.change_pulse !== 1'b0) begin failures++; $display("FAIL basic_no_change got=%b exp=0", bus.change_pulse); end
  endtask

  task automatic test_change;
    do_reset();
    repeat (3) insert_coin(2'b10);
    checks++; if (bus.credit !== 6'd30) begin failures++; $display("FAIL change_credit30 got=%0d exp=30", bus.credit); end
    bus.sel = 4'b0110; tick(); bus.sel = 4'b0000;
    checks++; if ({bus.motor_req, bus.motor_lane} !== 3'b101) begin
      failures++; $display("FAIL change_lane1 got=%b exp=101", {bus.motor_req, bus.motor_lane}); end
    bus.motor_ack = 1'b1; tick(); bus.motor_ack = 1'b0;
    checks++; if ({bus.motor_req, bus.change_pulse, bus.busy} !== 3'b011 || bus.credit !== 6'd10) begin
      failures++; $display("FAIL change_after_ack got=%b credit=%0d exp=011 credit=10", {bus.motor_req, bus.change_pulse, bus.busy}, bus.credit); end
    tick();
    checks++; if (bus.change_pulse !== 1'b0 || bus.credit !== 6'd5) begin
      failures++; $display("FAIL change_gap got=%b credit=%0d exp=0 credit=5", bus.change_pulse, bus.credit); end
    tick();
    checks++; if (bus.change_pulse !== 1'b1 || bus.credit !== 6'd5) begin
      failures++; $display("FAIL change_second got=%b credit=%0d exp=1 credit=5", bus.change_pulse, bus.credit); end
    tick();
    checks++; if ({bus.change_pulse, bus.busy} !== 2'b00 || bus.credit !== 6'd0) begin
      failures++; $display("FAIL change_idle got=%b credit=%0d exp=00 credit=0", {bus.change_pulse, bus.busy}, bus.credit); end
  endtask

  task automatic test_coin_reject;
    do_reset();
    repeat (3) insert_coin(2'b10);
    insert_coin(2'b10);
    checks++; if (bus.coin_reject !== 1'b1 || bus.credit !== 6'd30) begin
      failures++; $display("FAIL reject_over got=%b credit=%0d exp=1 credit=30", bus.coin_reject, bus.credit); end
    insert_coin(2'b01);
    checks++; if (bus.coin_reject !== 1'b0 || bus.credit !== 6'd35) begin
      failures++; $display("FAIL accept_max got=%b credit=%0d exp=0 credit=35", bus.coin_reject, bus.credit); end
    insert_coin(2'b01);
    checks++; if (bus.coin_reject !== 1'b1 || bus.credit !== 6'd35) begin
      failures++; $display("FAIL reject_at_max got=%b credit=%0d exp=1 credit=35", bus.coin_reject, bus.credit); end
    tick();
    checks++; if (bus.coin_reject !== 1'b0) begin failures++; $display("FAIL reject_one_cycle got=%b exp=0", bus.coin_reject); end
    do_reset();
    insert_coin(2'b11);
    checks++; if (bus.coin_reject !== 1'b1 || bus.credit !== 6'd0) begin
      failures++; $display("FAIL reject_invalid got=%b credit=%0d exp=1 credit=0", bus.coin_reject, bus.credit); end
  endtask

  task automatic test_ineligible;
    do_reset();
    insert_coin(2'b10);
    bus.sel = 4'b0111; tick();
    checks++; if ({bus.motor_req, bus.busy} !== 2'b00 || bus.credit !== 6'd10) begin
      failures++; $display("FAIL inelig_price got=%b credit=%0d exp=00 credit=10", {bus.motor_req, bus.busy}, bus.credit); end
    bus.sel = 4'b1111; bus.lane_empty = 4'b1000; tick();
    checks++; if (bus.motor_req !== 1'b0) begin failures++; $display("FAIL inelig_empty got=%b exp=0", bus.motor_req); end
    clear_inputs(); bus.motor_ack = 1'b1; tick(); bus.motor_ack = 1'b0;
    checks++; if (bus.busy !== 1'b0 || bus.credit !== 6'd10) begin
      failures++; $display("FAIL ack_in_idle got busy=%b credit=%0d exp=0 credit=10", bus.busy, bus.credit); end
    bus.sel = 4'b0001; bus.coin = 2'b01; tick();
    checks++; if ({bus.motor_req, bus.coin_reject} !== 2'b00 || bus.credit !== 6'd15) begin
      failures++; $display("FAIL precoin_elig got=%b credit=%0d exp=00 credit=15", {bus.motor_req, bus.coin_reject}, bus.credit); end
    bus.coin = 2'b10; tick(); clear_inputs();
    checks++; if ({bus.motor_req, bus.motor_lane, bus.coin_reject} !== 4'b1001 || bus.credit !== 6'd15) begin
      failures++; $display("FAIL grant_coin_reject got=%b credit=%0d exp=1001 credit=15", {bus.motor_req, bus.motor_lane, bus.coin_reject}, bus.credit); end
    bus.motor_ack = 1'b1; tick(); bus.motor_ack = 1'b0;
    checks++; if (bus.busy !== 1'b0 || bus.credit !== 6'd0) begin
      failures++; $display("FAIL inelig_final got busy=%b credit=%0d exp=0 credit=0", bus.busy, bus.credit); end
  endtask

  task automatic test_timeout;
    int cnt, pulses, extra_err, guard;
    logic prev, b2b;
    do_reset();
    insert_coin(2'b10); insert_coin(2'b10); insert_coin(2'b01);
    bus.sel = 4'b0100; tick(); bus.sel = 4'b0000;
    checks++; if ({bus.motor_req, bus.motor_lane} !== 3'b110 || bus.credit !== 6'd25) begin
      failures++; $display("FAIL tmo_grant got=%b credit=%0d exp=110 credit=25", {bus.motor_req, bus.motor_lane}, bus.credit); end
    insert_coin(2'b01);
    checks++; if (bus.coin_reject !== 1'b1 || bus.credit !== 6'd25) begin
      failures++; $display("FAIL vend_coin_reject got=%b credit=%0d exp=1 credit=25", bus.coin_reject, bus.credit); end
    cnt = 2; guard = 0; extra_err = 0;
    while (bus.motor_req === 1'b1 && guard < 40) begin
      if (bus.timeout_err === 1'b1) extra_err++;
      tick(); guard++;
      if (bus.motor_req === 1'b1) cnt++;
    end
    checks++; if (cnt !== 16) begin failures++; $display("FAIL tmo_req_cycles got=%0d exp=16", cnt); end
    checks++; if ({bus.timeout_err, bus.change_pulse, bus.busy} !== 3'b111 || bus.credit !== 6'd25 || extra_err !== 0) begin
      failures++; $display("FAIL tmo_err got=%b credit=%0d early=%0d exp=111 credit=25 early=0", {bus.timeout_err, bus.change_pulse, bus.busy}, bus.credit, extra_err); end
    pulses = 1; prev = 1'b1; b2b = 1'b0;
    for (int i = 0; i < 30 && bus.busy === 1'b1; i++) begin
      tick();
      if (bus.timeout_err === 1'b1) extra_err++;
      if (bus.change_pulse === 1'b1) begin
        if (prev) b2b = 1'b1;
        pulses++;
      end
      prev = bus.change_pulse;
    end
    checks++; if (pulses !== 5 || b2b !== 1'b0) begin failures++; $display("FAIL tmo_pulses got=%0d b2b=%b exp=5 b2b=0", pulses, b2b); end
    checks++; if (bus.credit !== 6'd0 || bus.busy !== 1'b0 || extra_err !== 0) begin
      failures++; $display("FAIL tmo_end got credit=%0d busy=%b errs=%0d exp=0 0 0", bus.credit, bus.busy, extra_err); end
  endtask

  task automatic test_refund;
    int pulses;
    do_reset();
    bus.refund = 1'b1; tick(); bus.refund = 1'b0;
    checks++; if ({bus.busy, bus.change_pulse} !== 2'b00) begin
      failures++; $display("FAIL refund_zero got=%b exp=00", {bus.busy, bus.change_pulse}); end
    insert_coin(2'b10); insert_coin(2'b10);
    bus.sel = 4'b1000; bus.lane_empty = 4'b1000; bus.refund = 1'b1; tick(); clear_inputs();
    checks++; if ({bus.motor_req, bus.busy, bus.change_pulse} !== 3'b011 || bus.credit !== 6'd20) begin
      failures++; $display("FAIL refund_enter got=%b credit=%0d exp=011 credit=20", {bus.motor_req, bus.busy, bus.change_pulse}, bus.credit); end
    pulses = 1;
    for (int i = 0; i < 30 && bus.busy === 1'b1; i++) begin
      tick();
      if (bus.change_pulse === 1'b1) pulses++;
    end
    checks++; if (pulses !== 4 || bus.credit !== 6'd0 || bus.busy !== 1'b0) begin
      failures++; $display("FAIL refund_pulses got=%0d credit=%0d busy=%b exp=4 credit=0 busy=0", pulses, bus.credit, bus.busy); end
    insert_coin(2'b10); insert_coin(2'b10);
    bus.sel = 4'b0001; bus.refund = 1'b1; tick(); clear_inputs();
    checks++; if ({bus.motor_req, bus.motor_lane, bus.change_pulse} !== 4'b1000) begin
      failures++; $display("FAIL grant_over_refund got=%b exp=1000", {bus.motor_req, bus.motor_lane, bus.change_pulse}); end
    bus.motor_ack = 1'b1; tick(); bus.motor_ack = 1'b0;
    checks++; if (bus.change_pulse !== 1'b1 || bus.credit !== 6'd5) begin
      failures++; $display("FAIL refund_vend_change got=%b credit=%0d exp=1 credit=5", bus.change_pulse, bus.credit); end
    tick();
    checks++; if (bus.busy !== 1'b0 || bus.credit !== 6'd0) begin
      failures++; $display("FAIL refund_vend_idle got busy=%b credit=%0d exp=0 credit=0", bus.busy, bus.credit); end
  endtask

  task automatic test_reset_mid_vend;
    do_reset();
    insert_coin(2'b10); insert_coin(2'b10);
    bus.sel = 4'b1000; tick(); bus.sel = 4'b0000;
    checks++; if ({bus.motor_req, bus.motor_lane} !== 3'b111 || bus.credit !== 6'd20) begin
      failures++; $display("FAIL midvend_grant got=%b credit=%0d exp=111 credit=20", {bus.motor_req, bus.motor_lane}, bus.credit); end
    reset = 1'b1; bus.coin = 2'b01; bus.refund = 1'b1; bus.sel = 4'b0001; tick();
    reset = 1'b0; clear_inputs();
    checks++; if ({bus.busy, bus.motor_req, bus.change_pulse, bus.coin_reject} !== 4'b0000 || bus.credit !== 6'd0) begin
      failures++; $display("FAIL midvend_reset got=%b credit=%0d exp=0000 credit=0", {bus.busy, bus.motor_req, bus.change_pulse, bus.coin_reject}, bus.credit); end
    tick();
    checks++; if ({bus.busy, bus.change_pulse} !== 2'b00 || bus.credit !== 6'd0) begin
      failures++; $display("FAIL midvend_after got=%b credit=%0d exp=00 credit=0", {bus.busy, bus.change_pulse}, bus.credit); end
  endtask

  initial begin
    reset = 1'b1;
    clear_inputs();
    tick();
    test_reset();
    test_basic_vend();
    test_change();
    test_coin_reject();
    test_ineligible();
    test_timeout();
    test_refund();
    test_reset_mid_vend();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
